truth_table_sequencer: RTL and testbench

Hardware sequencer that exhaustively characterises a small combinational/sequential DUT. It holds the DUT in reset, then applies every input vector 0..2^N_IN-1 in ascending order, waits a settle interval, and samples the DUT's single-bit output. Each (vector, response) pair streams out over a valid/ready record port and is also accumulated into a truth-table signature for golden/trojan comparison. It sits between the test-control logic and the DUT harness, replacing the free-running vector loop in the simulation benches.

---
 rtl/tts_pkg.sv | 34 +++
 rtl/tts_wait_timer.sv | 32 +++
 rtl/truth_table_sequencer.sv | 148 ++++++++++++++
 tb/tb_truth_table_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tts_pkg.sv
// Shared types and sizing helpers for the truth-table sequencer.
//   tts_state_e   : sequencer FSM states
//   tts_vec_count : number of input vectors for an N-input DUT
//   tts_cnt_w     : width of the vector counter
//   tts_wait_w    : wait-timer width covering max(SETTLE, RST_CYC)-1
package tts_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DUT_RST,
    S_APPLY,
    S_SETTLE,
    S_SAMPLE,
    S_EMIT,
    S_DONE
  } tts_state_e;

  function automatic int unsigned tts_vec_count(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

  function automatic int unsigned tts_cnt_w(input int unsigned n_in);
    return (n_in < 1) ? 1 : n_in;
  endfunction

  // Timer only ever holds (wait - 1), so clog2 of the larger wait suffices.
  function automatic int unsigned tts_wait_w(input int unsigned settle,
                                             input int unsigned rst_cyc);
    int unsigned m;
    m = (settle > rst_cyc) ? settle : rst_cyc;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/tts_wait_timer.sv
// Loadable down-counter with zero flag, shared by the DUT reset and
// settle waits of the sequencer.
//   CK       : clock, rising edge
//   reset    : asynchronous active-low reset
//   load     : load load_val this cycle (priority over counting)
//   load_val : value to load
//   zero     : counter is at zero (counting stops there)
module tts_wait_timer #(
  parameter int unsigned W = 1
) (
  input  logic         CK,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Exhaustive truth-table sequencer: resets the DUT, applies vectors
// 0..2^N_IN-1, samples the DUT output after a settle interval, streams
// each (vector, response) record and accumulates a signature.
//   CK, reset          : clock / asynchronous active-low reset
//   start, abort       : run request (IDLE only) / run termination
//   dut_rst, dut_n     : DUT reset and input vector (dut_n[N_IN-1] = LSB)
//   dut_out            : DUT response
//   rec_valid/ready    : record handshake; rec_vec, rec_bit = record
//   signature          : bit k = response to vector k
//   busy, done         : not-IDLE flag / run-complete pulse
module truth_table_sequencer
  import tts_pkg::*;
#(
  parameter int unsigned N_IN    = 4,
  parameter int unsigned SETTLE  = 1,
  parameter int unsigned RST_CYC = 2
) (
  input  logic                            CK,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            abort,
  output logic                            dut_rst,
  output logic [N_IN-1:0]                 dut_n,
  input  logic                            dut_out,
  output logic                            rec_valid,
  input  logic                            rec_ready,
  output logic [N_IN-1:0]                 rec_vec,
  output logic                            rec_bit,
  output logic [tts_vec_count(N_IN)-1:0]  signature,
  output logic                            busy,
  output logic                            done
);

  localparam int unsigned CNT_W  = tts_cnt_w(N_IN);
  localparam int unsigned WAIT_W = tts_wait_w(SETTLE, RST_CYC);
  localparam logic [WAIT_W-1:0] RST_LOAD    = WAIT_W'(RST_CYC - 1);
  localparam logic [WAIT_W-1:0] SETTLE_LOAD = WAIT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0]  LAST_VEC    = '1;

  tts_state_e        state, state_nx;
  logic [CNT_W-1:0]  count;
  logic [N_IN-1:0]   vec_rev;
  logic              tmr_load, tmr_zero;
  logic [WAIT_W-1:0] tmr_val;
  logic              clr_run, do_apply, do_sample, do_inc;

  tts_wait_timer #(.W(WAIT_W)) u_timer (
    .CK       (CK),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    tmr_load  = 1'b0;
    tmr_val   = RST_LOAD;
    clr_run   = 1'b0;
    do_apply  = 1'b0;
    do_sample = 1'b0;
    do_inc    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_nx = S_DUT_RST;
          tmr_load = 1'b1;
          tmr_val  = RST_LOAD;
          clr_run  = 1'b1;
        end
      end
      S_DUT_RST: if (tmr_zero) state_nx = S_APPLY;
      S_APPLY: begin
        state_nx = S_SETTLE;
        tmr_load = 1'b1;
        tmr_val  = SETTLE_LOAD;
        do_apply = 1'b1;
      end
      S_SETTLE: if (tmr_zero) state_nx = S_SAMPLE;
      S_SAMPLE: begin
        state_nx  = S_EMIT;
        do_sample = 1'b1;
      end
      S_EMIT: begin
        if (rec_ready) begin
          if (count == LAST_VEC) begin
            state_nx = S_DONE;
          end else begin
            state_nx = S_APPLY;
            do_inc   = 1'b1;
          end
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    // Abort overrides everything, including a same-cycle handshake.
    if (abort && state != S_IDLE) begin
      state_nx  = S_IDLE;
      tmr_load  = 1'b0;
      do_apply  = 1'b0;
      do_sample = 1'b0;
      do_inc    = 1'b0;
    end
  end

  // dut_n is bit-reversed: the counter LSB drives dut_n[N_IN-1].
  always_comb begin
    vec_rev = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      vec_rev[i] = count[N_IN-1-i];
    end
  end

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      dut_n     <= '0;
      signature <= '0;
      rec_vec   <= '0;
      rec_bit   <= 1'b0;
    end else begin
      if (clr_run) begin
        count     <= '0;
        dut_n     <= '0;
        signature <= '0;
      end
      if (do_apply) dut_n <= vec_rev;
      if (do_sample) begin
        signature[count] <= dut_out;
        rec_bit          <= dut_out;
        rec_vec          <= count;
      end
      if (do_inc) count <= count + 1'b1;
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign rec_valid = (state == S_EMIT);
  assign dut_rst   = (state == S_DUT_RST);

endmodule

// File: tb/tb_truth_table_sequencer.sv
module tb_truth_table_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // DUT behaviour models: 0 = AND, 1 = XOR parity, 2 = OR
  function automatic logic fmod(input int m, input int unsigned n, input int unsigned v);
    logic [7:0] b;
    b = 8'(v);
    case (m)
      0:       return (v == ((32'd1 << n) - 1));
      1:       return ^b;
      default: return (v != 0);
    endcase
  endfunction

  function automatic logic [3:0] rev4(input logic [3:0] x);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = x[3-i];
    return r;
  endfunction

  function automatic logic [1:0] rev2(input logic [1:0] x);
    return {x[0], x[1]};
  endfunction

  // ---------------- instance 1: defaults ----------------
  logic        rst_n, start, abort, dut_rst, dut_out, rec_valid, rec_ready, rec_bit, busy, done;
  logic [3:0]  dut_n, rec_vec;
  logic [15:0] signature;
  int          mode = 0;

  assign dut_out = fmod(mode, 4, {28'd0, rev4(dut_n)});

  truth_table_sequencer #(.N_IN(4), .SETTLE(1), .RST_CYC(2)) u_dut (
    .CK(clk), .reset(rst_n), .start(start), .abort(abort),
    .dut_rst(dut_rst), .dut_n(dut_n), .dut_out(dut_out),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_vec(rec_vec), .rec_bit(rec_bit),
    .signature(signature), .busy(busy), .done(done)
  );

  // ---------------- instance 2: N_IN=2, SETTLE=3, RST_CYC=1, OR ----------------
  logic        rst2_n, start2, abort2, dut_rst2, dut_out2, rec_valid2, rec_ready2, rec_bit2, busy2, done2;
  logic [1:0]  dut_n2, rec_vec2;
  logic [3:0]  signature2;

  assign dut_out2 = fmod(2, 2, {30'd0, rev2(dut_n2)});

  truth_table_sequencer #(.N_IN(2), .SETTLE(3), .RST_CYC(1)) u_dut2 (
    .CK(clk), .reset(rst2_n), .start(start2), .abort(abort2),
    .dut_rst(dut_rst2), .dut_n(dut_n2), .dut_out(dut_out2),
    .rec_valid(rec_valid2), .rec_ready(rec_ready2), .rec_vec(rec_vec2), .rec_bit(rec_bit2),
    .signature(signature2), .busy(busy2), .done(done2)
  );

  // ---------------- scoreboards ----------------
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  int unsigned done_cnt1 = 0;
  logic        held_v = 1'b0;
  logic [3:0]  held_vec;
  logic        held_bit;
  logic [3:0]  held_dn;

  task automatic push_run1(input int m);
    for (int unsigned v = 0; v < 16; v++) q1.push_back({v[30:0], fmod(m, 4, v)});
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n && rec_valid) begin
      check("dut_n_matches_rec", {28'd0, dut_n}, {28'd0, rev4(rec_vec)});
      if (held_v) begin
        check("hold_vec", {28'd0, rec_vec}, {28'd0, held_vec});
        check("hold_bit", {31'd0, rec_bit}, {31'd0, held_bit});
        check("hold_dut_n", {28'd0, dut_n}, {28'd0, held_dn});
      end
      if (rec_ready) begin
        check("rec_not_extra", {31'd0, q1.size() != 0}, 32'd1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          check("rec_vec", {28'd0, rec_vec}, e >> 1);
          check("rec_bit", {31'd0, rec_bit}, {31'd0, e[0]});
        end
        held_v = 1'b0;
      end else begin
        held_v   = 1'b1;
        held_vec = rec_vec;
        held_bit = rec_bit;
        held_dn  = dut_n;
      end
    end else begin
      held_v = 1'b0;
    end
    if (rst_n && done) done_cnt1++;
  end

  always @(negedge clk) begin
    logic [31:0] e;
    if (rst2_n && rec_valid2 && rec_ready2) begin
      check("rec2_not_extra", {31'd0, q2.size() != 0}, 32'd1);
      if (q2.size() != 0) begin
        e = q2.pop_front();
        check("rec2_vec", {30'd0, rec_vec2}, e >> 1);
        check("rec2_bit", {31'd0, rec_bit2}, {31'd0, e[0]});
        check("dut_n2_matches_rec", {30'd0, dut_n2}, {30'd0, rev2(rec_vec2)});
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one step after the edge that sampled start; returns edges until done is seen.
  task automatic wait_done1(input int unsigned max, output int unsigned edges);
    edges = 0;
    while (!done && edges < max) begin
      tick();
      edges++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin : stim
    int unsigned edges, n, dc, rst_hi;
    logic [15:0] exp_sig;
    rst_n = 1'b0; rst2_n = 1'b0;
    start = 1'b0; abort = 1'b0; rec_ready = 1'b1;
    start2 = 1'b0; abort2 = 1'b0; rec_ready2 = 1'b1;
    #3;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_dut_rst", {31'd0, dut_rst}, 32'd0);
    check("rst_rec_valid", {31'd0, rec_valid}, 32'd0);
    check("rst_signature", {16'd0, signature}, 32'd0);
    check("rst_dut_n", {28'd0, dut_n}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    #9 rst_n = 1'b1; rst2_n = 1'b1;
    tick(); tick();

    // Test 1: AND DUT, ready tied high
    mode = 0;
    push_run1(0);
    start = 1'b1; tick(); start = 1'b0;
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_dut_rst", {31'd0, dut_rst}, 32'd1);
    dc = done_cnt1;
    wait_done1(200, edges);
    check("t1_done_cycle", edges + 1, 32'd67);
    check("t1_signature", {16'd0, signature}, 32'h8000);
    tick();
    check("t1_idle", {31'd0, busy}, 32'd0);
    check("t1_queue_empty", q1.size(), 32'd0);
    check("t1_one_done", done_cnt1 - dc, 32'd1);

    // Test 2: parity DUT, ready pattern 1-0-1 (period 3 to catch stalls)
    mode = 1;
    push_run1(1);
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!done && n < 600) begin
      rec_ready = ((n % 3) != 1);
      tick();
      n++;
    end
    check("t2_done_seen", {31'd0, done}, 32'd1);
    rec_ready = 1'b1;
    exp_sig = '0;
    for (int unsigned k = 0; k < 16; k++) exp_sig[k] = fmod(1, 4, k);
    check("t2_signature_model", {16'd0, signature}, {16'd0, exp_sig});
    check("t2_signature", {16'd0, signature}, 32'h6996);
    tick();
    check("t2_queue_empty", q1.size(), 32'd0);

    // Test 3: abort during EMIT of vector 0101
    push_run1(1);
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!(rec_valid && rec_vec == 4'd5) && n < 200) begin
      tick();
      n++;
    end
    check("t3_reached_v5", {31'd0, rec_valid && rec_vec == 4'd5}, 32'd1);
    dc = done_cnt1;
    abort = 1'b1; rec_ready = 1'b0;
    tick();
    abort = 1'b0; rec_ready = 1'b1;
    q1.delete();
    check("t3_idle", {31'd0, busy}, 32'd0);
    check("t3_rec_valid", {31'd0, rec_valid}, 32'd0);
    check("t3_dut_rst", {31'd0, dut_rst}, 32'd0);
    check("t3_partial_sig", {16'd0, signature}, 32'h0016);
    tick(); tick(); tick();
    check("t3_no_done", done_cnt1 - dc, 32'd0);
    check("t3_still_idle", {31'd0, busy}, 32'd0);
    push_run1(1);
    start = 1'b1; tick(); start = 1'b0;
    wait_done1(200, edges);
    check("t3_rerun_sig", {16'd0, signature}, 32'h6996);
    tick();

    // Test 4: start held high for the whole run
    push_run1(1);
    dc = done_cnt1;
    start = 1'b1; tick();
    wait_done1(200, edges);
    start = 1'b0;
    check("t4_done_cycle", edges + 1, 32'd67);
    tick();
    check("t4_idle", {31'd0, busy}, 32'd0);
    tick(); tick(); tick();
    check("t4_one_run", done_cnt1 - dc, 32'd1);
    check("t4_stays_idle", {31'd0, busy}, 32'd0);
    mode = 0;
    push_run1(0);
    start = 1'b1; tick(); start = 1'b0;
    check("t4_sig_cleared", {16'd0, signature}, 32'd0);
    wait_done1(200, edges);
    check("t4_second_sig", {16'd0, signature}, 32'h8000);
    tick();

    // Test 5: asynchronous reset at vector 7
    mode = 1;
    push_run1(1);
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!(rec_valid && rec_vec == 4'd7) && n < 200) begin
      tick();
      n++;
    end
    check("t5_reached_v7", {31'd0, rec_valid && rec_vec == 4'd7}, 32'd1);
    rst_n = 1'b0;
    #1;
    q1.delete();
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_rec_valid", {31'd0, rec_valid}, 32'd0);
    check("t5_rec_vec", {28'd0, rec_vec}, 32'd0);
    check("t5_rec_bit", {31'd0, rec_bit}, 32'd0);
    check("t5_dut_n", {28'd0, dut_n}, 32'd0);
    check("t5_signature", {16'd0, signature}, 32'd0);
    check("t5_dut_rst", {31'd0, dut_rst}, 32'd0);
    #2 rst_n = 1'b1;
    tick(); tick(); tick(); tick();
    check("t5_no_activity", {31'd0, busy || dut_rst}, 32'd0);

    // Test 6: N_IN=2, SETTLE=3, RST_CYC=1, OR DUT
    for (int unsigned v = 0; v < 4; v++) q2.push_back({v[30:0], fmod(2, 2, v)});
    start2 = 1'b1; tick(); start2 = 1'b0;
    rst_hi = dut_rst2 ? 1 : 0;
    n = 0;
    while (!done2 && n < 100) begin
      tick();
      n++;
      if (dut_rst2) rst_hi++;
    end
    check("t6_done_seen", {31'd0, done2}, 32'd1);
    check("t6_done_cycle", n + 1, 32'd26);
    check("t6_rst_cycles", rst_hi, 32'd1);
    check("t6_signature", {28'd0, signature2}, 32'h0000000E);
    tick();
    check("t6_queue_empty", q2.size(), 32'd0);
    check("t6_idle", {31'd0, busy2}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
